vga_capture: RTL and testbench
==============================

Name: vga_capture

Overview:
- Pixel-side receiver/checker for the VGA output stream: consumes the hsync/vsync/blank/RGB outputs of the vga timing block.
- Recovers pixel position, writes each active pixel into a frame-buffer write port and accumulates a per-frame checksum.
- Reports lock and format errors so benches and on-chip self-test can compare captured frames against the source image.
- Sits on the 27 MHz pixel clock domain, directly downstream of vga.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- H_TOTAL, 800, pixel clocks per line (timing check only)
- V_TOTAL, 525, lines per frame (timing check only)
- DW, 10, bits per colour channel
- AW, 19, frame-buffer address width (must hold H_ACTIVE*V_ACTIVE-1)

Ports:
- i_clk_27  in  1  pixel clock; all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_hsync  in  1  horizontal sync, active low
- i_vsync  in  1  vertical sync, active low
- i_vga_blank  in  1  blank_n: 1 = active video, 0 = blanking
- i_red, i_green, i_blue  in  DW each  pixel colour
- o_wr_en  out  1  frame-buffer write strobe
- o_wr_addr  out  AW  linear pixel index, y*H_ACTIVE+x
- o_wr_data  out  3*DW  {red,green,blue}
- o_frame_done  out  1  one-cycle pulse at frame end
- o_frame_sum  out  32  checksum of last completed frame
- o_pix_count  out  AW+1  active pixels in last completed frame
- o_locked  out  1  two consecutive good frames seen
- o_line_err  out  1  sticky: a line had an active run length other than H_ACTIVE
- o_frame_err  out  1  last completed frame was bad
- o_timing_err  out  1  see Optional Feature

Behaviour:
- Reset, asynchronous, i_rst_n=0: every output is 0, all counters are 0, and the FSM goes to SEARCH.
- Input stage: all inputs are registered once (stage r1). Edges are detected between r1 and a second register r2.
- Latency: a pixel sampled at edge k gives o_wr_en/o_wr_addr/o_wr_data at edge k+1. The fixed latency is 2 edges from pin to output.
- vsync edge: the falling edge of the registered vsync (assertion) is the frame boundary.
- FSM SEARCH:
  - Ignore pixels; o_wr_en=0.
  - On a vsync edge, go to FRAME and clear the address, sum, pixel and line counters.
- FSM FRAME, per cycle with blank_n=1:
  - If x<H_ACTIVE and y<V_ACTIVE: o_wr_en=1, o_wr_addr=addr, addr+=1, x+=1, sum+=zero-extended 3*DW data (mod 2^32), pix_count+=1.
  - Otherwise: drop the pixel (o_wr_en=0) and mark the frame bad.
- FSM FRAME, falling edge of blank_n (end of an active run):
  - If x != H_ACTIVE, set o_line_err (sticky until reset) and mark the frame bad.
  - Then x=0 and y+=1.
- FSM FRAME, vsync edge (frame end):
  - The frame is good if pix_count == H_ACTIVE*V_ACTIVE, y == V_ACTIVE and it is not marked bad.
  - Latch o_frame_sum and o_pix_count. Pulse o_frame_done for 1 cycle. Set o_frame_err to !good.
  - Restart the counters for the next frame in the same cycle; stay in FRAME.
- Lock counter (2 bits, saturating at 2): a good frame increments it; a bad frame clears it and deasserts o_locked at once. o_locked = (count==2).
- Simultaneous blank_n falling edge and vsync edge: process the line end first, then evaluate the frame.
- Active pixel in the same cycle as a vsync edge: the pixel belongs to the new frame.
- Reset mid-frame: the partial frame is discarded and the next frame is captured only after a fresh vsync edge.
- Address never exceeds H_ACTIVE*V_ACTIVE-1, because overflow pixels are dropped.

Optional Feature:
- Macro VGA_CAPTURE_TIMING_CHK_EN.
- Defined:
  - Count clocks between hsync assertion edges. Any period != H_TOTAL sets o_timing_err.
  - Count hsync edges between vsync edges. A value != V_TOTAL at frame end sets o_timing_err.
  - o_timing_err is sticky until reset. The first partial line and partial frame after SEARCH are excluded.
- Undefined: o_timing_err is tied to 0 and the period counters are not synthesised.

Test Plan:
- Reset, then 3 frames of 640x480 at 800x525 timing with constant pixel {10'h3FF,0,0} -> per frame 307200 writes, o_wr_addr 0..307199, o_pix_count=307200, o_frame_sum=307200*32'h3FF00000 mod 2^32=32'h00000000. o_locked=1 after the 2nd frame_done.
- Pixel value = address LSBs (red=addr[9:0], green=blue=0) -> o_wr_data matches o_wr_addr on every write, 2-edge latency from pins, o_frame_sum equals the bench model sum.
- One line shortened to 639 active pixels in frame 2 -> o_line_err=1, o_frame_err=1 at that frame_done, o_locked drops to 0, then relocks after 2 further good frames.
- Extra 481st active line -> its 640 pixels are not written, max address stays 307199, o_frame_err=1.
- i_rst_n pulsed low at line 200 -> all outputs 0 immediately. The next write has address 0 and occurs only after a new vsync edge.
- With VGA_CAPTURE_TIMING_CHK_EN defined, one line of 801 clocks -> o_timing_err=1 and stays 1. Without the macro -> o_timing_err stays 0.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture -- pixel-side receiver/checker for the VGA output stream.
//
// Registers the sync/blank/RGB outputs of the vga timing block and
// recovers the pixel position from them. Each active pixel goes to a
// frame-buffer write port. A checksum and a pixel count are kept per
// frame, and lock and format errors are reported.
//
// Optional feature, enabled with `define VGA_CAPTURE_TIMING_CHK_EN:
// checks the hsync period against H_TOTAL and the lines per frame
// against V_TOTAL. Without the macro, o_timing_err is tied to 0.
//
// Ports:
//   i_clk_27      pixel clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_hsync       horizontal sync, active low
//   i_vsync       vertical sync, active low (falling edge = frame boundary)
//   i_vga_blank   blank_n: 1 = active video
//   i_red/green/blue  pixel colour, DW bits each
//   o_wr_en       frame-buffer write strobe
//   o_wr_addr     linear pixel index y*H_ACTIVE+x
//   o_wr_data     {red,green,blue}
//   o_frame_done  one-cycle pulse at frame end
//   o_frame_sum   checksum of last completed frame
//   o_pix_count   active pixels in last completed frame
//   o_locked      two consecutive good frames seen
//   o_line_err    sticky: an active run length was not H_ACTIVE
//   o_frame_err   last completed frame was bad
//   o_timing_err  sticky hsync-period / line-count error (optional)
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int DW       = 10,
  parameter int AW       = 19
) (
  input  logic            i_clk_27,
  input  logic            i_rst_n,
  input  logic            i_hsync,
  input  logic            i_vsync,
  input  logic            i_vga_blank,
  input  logic [DW-1:0]   i_red,
  input  logic [DW-1:0]   i_green,
  input  logic [DW-1:0]   i_blue,
  output logic            o_wr_en,
  output logic [AW-1:0]   o_wr_addr,
  output logic [3*DW-1:0] o_wr_data,
  output logic            o_frame_done,
  output logic [31:0]     o_frame_sum,
  output logic [AW:0]     o_pix_count,
  output logic            o_locked,
  output logic            o_line_err,
  output logic            o_frame_err,
  output logic            o_timing_err
);

  // x and y saturate one past the active size, so overlong runs and
  // extra lines stay distinguishable without wrapping.
  localparam int XW = $clog2(H_ACTIVE + 2);
  localparam int YW = $clog2(V_ACTIVE + 2);
  localparam logic [XW-1:0] X_END    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_MAX    = XW'(H_ACTIVE + 1);
  localparam logic [YW-1:0] Y_END    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_MAX    = YW'(V_ACTIVE + 1);
  localparam logic [AW:0]   PIX_FULL = (AW+1)'(H_ACTIVE * V_ACTIVE);

  typedef enum logic {S_SEARCH, S_FRAME} state_e;

  // Input stage: r1 is the sampled pin, r2 the previous r1 for edges.
  logic            vs_r1, vs_r2, bl_r1, bl_r2;
  logic [3*DW-1:0] pix_r1;

  // NOTE: clocked state always uses non-blocking assignments so every
  // flop samples its inputs from before the edge.
  always_ff @(posedge i_clk_27 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vs_r1  <= 1'b0;
      vs_r2  <= 1'b0;
      bl_r1  <= 1'b0;
      bl_r2  <= 1'b0;
      pix_r1 <= '0;
    end else begin
      vs_r1  <= i_vsync;
      vs_r2  <= vs_r1;
      bl_r1  <= i_vga_blank;
      bl_r2  <= bl_r1;
      pix_r1 <= {i_red, i_green, i_blue};
    end
  end

  logic vs_edge, line_end;
  assign vs_edge  = vs_r2 & ~vs_r1;   // vsync assertion
  assign line_end = bl_r2 & ~bl_r1;   // end of an active run

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     sum_q, sum_d;
  logic [AW:0]     pix_q, pix_d;
  logic            bad_q, bad_d;
  logic [1:0]      lock_q, lock_d;
  logic            good;
  logic            wr_en_d, done_d, locked_d, line_err_d, frame_err_d;
  logic [AW-1:0]   wr_addr_d;
  logic [3*DW-1:0] wr_data_d;
  logic [31:0]     fsum_d;
  logic [AW:0]     fpix_d;

  // NOTE: every variable gets a default at the top of the block, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    sum_d       = sum_q;
    pix_d       = pix_q;
    bad_d       = bad_q;
    lock_d      = lock_q;
    good        = 1'b0;
    wr_en_d     = 1'b0;
    wr_addr_d   = o_wr_addr;
    wr_data_d   = o_wr_data;
    done_d      = 1'b0;
    fsum_d      = o_frame_sum;
    fpix_d      = o_pix_count;
    line_err_d  = o_line_err;
    frame_err_d = o_frame_err;

    unique case (state_q)
      S_SEARCH: begin
        if (vs_edge) begin
          state_d = S_FRAME;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          sum_d   = '0;
          pix_d   = '0;
          bad_d   = 1'b0;
        end
      end
      S_FRAME: begin
        // Line end is processed before the frame is judged.
        if (line_end) begin
          if (x_q != X_END) begin
            line_err_d = 1'b1;
            bad_d      = 1'b1;
          end
          x_d = '0;
          if (y_q != Y_MAX) y_d = y_q + 1'b1;
        end
        if (vs_edge) begin
          good        = (pix_q == PIX_FULL) && (y_d == Y_END) && !bad_d;
          fsum_d      = sum_q;
          fpix_d      = pix_q;
          done_d      = 1'b1;
          frame_err_d = !good;
          if (!good)               lock_d = 2'd0;
          else if (lock_q != 2'd2) lock_d = lock_q + 2'd1;
          x_d    = '0;
          y_d    = '0;
          addr_d = '0;
          sum_d  = '0;
          pix_d  = '0;
          bad_d  = 1'b0;
        end
      end
    endcase

    // A pixel coinciding with the vsync edge belongs to the new frame,
    // so it is handled after the counters have been restarted.
    if (state_d == S_FRAME && bl_r1) begin
      if (x_d < X_END && y_d < Y_END) begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_d;
        wr_data_d = pix_r1;
        addr_d    = addr_d + 1'b1;
        sum_d     = sum_d + 32'(pix_r1);
        pix_d     = pix_d + 1'b1;
      end else begin
        bad_d = 1'b1;
      end
      if (x_d != X_MAX) x_d = x_d + 1'b1;
    end

    locked_d = (lock_d == 2'd2);
  end

  always_ff @(posedge i_clk_27 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_SEARCH;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      sum_q        <= '0;
      pix_q        <= '0;
      bad_q        <= 1'b0;
      lock_q       <= 2'd0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_frame_done <= 1'b0;
      o_frame_sum  <= '0;
      o_pix_count  <= '0;
      o_locked     <= 1'b0;
      o_line_err   <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      sum_q        <= sum_d;
      pix_q        <= pix_d;
      bad_q        <= bad_d;
      lock_q       <= lock_d;
      o_wr_en      <= wr_en_d;
      o_wr_addr    <= wr_addr_d;
      o_wr_data    <= wr_data_d;
      o_frame_done <= done_d;
      o_frame_sum  <= fsum_d;
      o_pix_count  <= fpix_d;
      o_locked     <= locked_d;
      o_line_err   <= line_err_d;
      o_frame_err  <= frame_err_d;
    end
  end

`ifdef VGA_CAPTURE_TIMING_CHK_EN
  localparam int HCW = $clog2(H_TOTAL + 2);
  localparam int VCW = $clog2(V_TOTAL + 2);
  localparam logic [HCW-1:0] H_END = HCW'(H_TOTAL);
  localparam logic [HCW-1:0] H_SAT = HCW'(H_TOTAL + 1);
  localparam logic [VCW-1:0] V_END = VCW'(V_TOTAL);
  localparam logic [VCW-1:0] V_SAT = VCW'(V_TOTAL + 1);

  logic           hs_r1, hs_r2, hs_edge, h_seen_q, tmg_err_q;
  logic [HCW-1:0] h_cnt_q;
  logic [VCW-1:0] v_cnt_q;

  assign hs_edge = hs_r2 & ~hs_r1;

  // h_cnt is 1 in the cycle of an hsync edge, so at the next edge it
  // holds the period in clocks. v_cnt counts hsync edges since vsync.
  always_ff @(posedge i_clk_27 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hs_r1     <= 1'b0;
      hs_r2     <= 1'b0;
      h_seen_q  <= 1'b0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      tmg_err_q <= 1'b0;
    end else begin
      hs_r1 <= i_hsync;
      hs_r2 <= hs_r1;
      if (state_q == S_SEARCH) begin
        // Partial line and frame before lock-on are not judged.
        h_seen_q <= 1'b0;
        h_cnt_q  <= '0;
        v_cnt_q  <= (vs_edge && hs_edge) ? VCW'(1) : '0;
      end else begin
        if (hs_edge) begin
          if (h_seen_q && h_cnt_q != H_END) tmg_err_q <= 1'b1;
          h_seen_q <= 1'b1;
          h_cnt_q  <= HCW'(1);
        end else if (h_cnt_q != H_SAT) begin
          h_cnt_q <= h_cnt_q + 1'b1;
        end
        if (vs_edge) begin
          if (v_cnt_q != V_END) tmg_err_q <= 1'b1;
          v_cnt_q <= hs_edge ? VCW'(1) : '0;
        end else if (hs_edge && v_cnt_q != V_SAT) begin
          v_cnt_q <= v_cnt_q + 1'b1;
        end
      end
    end
  end

  assign o_timing_err = tmg_err_q;
`else
  logic unused_hsync;
  assign unused_hsync = i_hsync;
  assign o_timing_err = 1'b0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
`timescale 1ns/1ps
// Bench for vga_capture on a reduced 8x4 raster (12x7 total) so many
// frames fit in a short run. A driver generates sync/blank/RGB from a
// table of frame scenarios and pushes expected writes and per-frame
// results into queues; monitors pop and compare as the DUT produces them.
module tb_vga_capture;
  localparam int H_ACTIVE = 8;
  localparam int V_ACTIVE = 4;
  localparam int H_TOTAL  = 12;
  localparam int V_TOTAL  = 7;
  localparam int DW       = 10;
  localparam int AW       = 5;
  localparam int PW       = 3 * DW;
  localparam int NPIX     = H_ACTIVE * V_ACTIVE;
  localparam int HS_COL   = 9;            // hsync low on columns 9..10
  localparam int VS_LINE  = V_ACTIVE + 1; // vsync low for this whole line
  localparam int NVEC     = 12;

`ifdef VGA_CAPTURE_TIMING_CHK_EN
  localparam bit TMG_EN = 1'b1;
`else
  localparam bit TMG_EN = 1'b0;
`endif

  typedef enum {M_GOOD, M_SHORT, M_EXTRA, M_HLONG, M_RESET} mode_e;
  typedef enum {P_CONST, P_ADDR, P_RAND} pat_e;
  typedef struct {
    mode_e mode;
    pat_e  pat;
    bit    err;       // expected o_frame_err at this frame_done
    bit    lock;      // expected o_locked
    bit    line_err;  // expected o_line_err
    bit    tmg;       // expected o_timing_err when the check is built in
  } frame_vec_t;
  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [PW-1:0] data;
  } wr_exp_t;
  typedef struct {
    logic [31:0] sum;
    logic [AW:0] pix;
    bit          err;
    bit          lock;
    bit          line_err;
    bit          tmg;
  } frm_exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hsync, vsync, blank;
  logic [DW-1:0] red, green, blue;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
  logic          frame_done;
  logic [31:0]   frame_sum;
  logic [AW:0]   pix_count;
  logic          locked, line_err, frame_err, timing_err;

  vga_capture #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL), .DW(DW), .AW(AW)
  ) dut (
    .i_clk_27    (clk),
    .i_rst_n     (rst_n),
    .i_hsync     (hsync),
    .i_vsync     (vsync),
    .i_vga_blank (blank),
    .i_red       (red),
    .i_green     (green),
    .i_blue      (blue),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_frame_done(frame_done),
    .o_frame_sum (frame_sum),
    .o_pix_count (pix_count),
    .o_locked    (locked),
    .o_line_err  (line_err),
    .o_frame_err (frame_err),
    .o_timing_err(timing_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_wr_en"},      64'(wr_en),      64'd0);
    check({pfx, "_wr_addr"},    64'(wr_addr),    64'd0);
    check({pfx, "_wr_data"},    64'(wr_data),    64'd0);
    check({pfx, "_frame_done"}, 64'(frame_done), 64'd0);
    check({pfx, "_frame_sum"},  64'(frame_sum),  64'd0);
    check({pfx, "_pix_count"},  64'(pix_count),  64'd0);
    check({pfx, "_locked"},     64'(locked),     64'd0);
    check({pfx, "_line_err"},   64'(line_err),   64'd0);
    check({pfx, "_frame_err"},  64'(frame_err),  64'd0);
    check({pfx, "_timing_err"}, 64'(timing_err), 64'd0);
  endtask

  // Scoreboards and the driver-side model of the capture.
  wr_exp_t       wq[$];
  frm_exp_t      fq[$];
  bit            capture = 1'b0;
  logic [AW-1:0] addr_m;
  logic [31:0]   sum_m;
  int            pix_m;

  // Write monitor: every strobe must match the next expected pixel,
  // including its arrival cycle (two edges after the pins).
  wr_exp_t we;
  int      max_addr = 0;
  always @(negedge clk) begin
    if (wr_en) begin
      check("wr_expected", 64'(wq.size() != 0), 64'd1);
      if (wq.size() != 0) begin
        we = wq.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(we.addr));
        check("wr_data", 64'(wr_data), 64'(we.data));
        check("wr_latency_cycle", 64'(cyc), 64'(we.cyc));
      end
      if (int'(wr_addr) > max_addr) max_addr = int'(wr_addr);
    end
  end

  // Frame monitor.
  frm_exp_t fe;
  int       frames_seen = 0;
  always @(negedge clk) begin
    if (frame_done) begin
      frames_seen++;
      check("frame_expected", 64'(fq.size() != 0), 64'd1);
      if (fq.size() != 0) begin
        fe = fq.pop_front();
        check("frame_sum",  64'(frame_sum),  64'(fe.sum));
        check("pix_count",  64'(pix_count),  64'(fe.pix));
        check("frame_err",  64'(frame_err),  64'(fe.err));
        check("locked",     64'(locked),     64'(fe.lock));
        check("line_err",   64'(line_err),   64'(fe.line_err));
        check("timing_err", 64'(timing_err), 64'(fe.tmg));
      end
    end
  end

  // Drives lines first..V_TOTAL-1 of one frame, one column per cycle.
  task automatic drive_lines(input frame_vec_t v, input int first);
    for (int ln = first; ln < V_TOTAL; ln++) begin
      int ncols;
      ncols = (v.mode == M_HLONG && ln == 1) ? H_TOTAL + 1 : H_TOTAL;
      for (int c = 0; c < ncols; c++) begin
        bit            act;
        logic [PW-1:0] d;
        @(negedge clk);
        if (v.mode == M_RESET && ln == 2 && c == 0) begin
          rst_n = 1'b0;
          #1;
          check_zero_outputs("midreset");
          capture = 1'b0;
        end
        if (v.mode == M_RESET && ln == 2 && c == 3) rst_n = 1'b1;

        act = (c < H_ACTIVE)
              && (ln < V_ACTIVE || (v.mode == M_EXTRA && ln == V_ACTIVE))
              && !(v.mode == M_SHORT && ln == 1 && c == H_ACTIVE - 1);

        if (ln == VS_LINE && c == 0) begin
          if (capture)
            fq.push_back('{sum_m, (AW+1)'(pix_m), v.err, v.lock, v.line_err,
                           TMG_EN & v.tmg});
          capture = 1'b1;
          addr_m  = '0;
          sum_m   = '0;
          pix_m   = 0;
        end

        d = PW'($urandom);
        if (act && v.pat != P_RAND) begin
          d = '0;
          if (v.pat == P_CONST) d[PW-1 -: DW] = '1;
          else                  d[PW-1 -: DW] = DW'(addr_m);
        end

        hsync = !(c == HS_COL || c == HS_COL + 1);
        vsync = (ln != VS_LINE);
        blank = act;
        {red, green, blue} = d;

        if (capture && act && ln < V_ACTIVE) begin
          wq.push_back('{cyc + 2, addr_m, d});
          addr_m = addr_m + 1'b1;
          sum_m  = sum_m + 32'(d);
          pix_m++;
        end
      end
    end
  endtask

  frame_vec_t vecs[NVEC];
  frame_vec_t pre;

  initial begin
    //                mode     pat      err lock line tmg
    vecs[0]  = '{M_GOOD,  P_CONST, 0, 0, 0, 0};
    vecs[1]  = '{M_GOOD,  P_ADDR,  0, 1, 0, 0};
    vecs[2]  = '{M_GOOD,  P_CONST, 0, 1, 0, 0};
    vecs[3]  = '{M_SHORT, P_ADDR,  1, 0, 1, 0};
    vecs[4]  = '{M_GOOD,  P_RAND,  0, 0, 1, 0};
    vecs[5]  = '{M_GOOD,  P_ADDR,  0, 1, 1, 0};
    vecs[6]  = '{M_EXTRA, P_ADDR,  1, 0, 1, 0};
    vecs[7]  = '{M_HLONG, P_ADDR,  0, 0, 1, 1};
    vecs[8]  = '{M_GOOD,  P_RAND,  0, 1, 1, 1};
    vecs[9]  = '{M_RESET, P_ADDR,  0, 0, 0, 0};
    vecs[10] = '{M_GOOD,  P_ADDR,  0, 0, 0, 0};
    vecs[11] = '{M_GOOD,  P_CONST, 0, 1, 0, 0};
    pre      = '{M_GOOD,  P_CONST, 0, 0, 0, 0};

    rst_n = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    blank = 1'b0;
    red   = '0;
    green = '0;
    blue  = '0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Partial frame: its vsync takes the DUT out of SEARCH.
    drive_lines(pre, VS_LINE);
    for (int i = 0; i < NVEC; i++) drive_lines(vecs[i], 0);
    repeat (4) @(negedge clk);

    check("writes_drained", 64'(wq.size()), 64'd0);
    check("frames_drained", 64'(fq.size()), 64'd0);
    check("frames_seen", 64'(frames_seen), 64'(NVEC - 1));
    check("max_addr", 64'(max_addr), 64'(NPIX - 1));
    check("final_timing_err", 64'(timing_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
